// File: rtl/encoder_scheduler_if.sv
// Grant/config bus of the encoder lane scheduler.
// slave  : scheduler side (takes requests and config, drives the grant, clear, error and busy signals)
// master : requester/consumer side
interface encoder_scheduler_if #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned LANE_W    = 8,
    parameter int unsigned IDX_W     = 2
);
    logic [NUM_LANES*LANE_W-1:0] req_vec;
    logic [IDX_W-1:0]            cfg_left;
    logic [IDX_W-1:0]            cfg_right;
    logic                        cfg_load;
    logic                        cfg_err;
    logic                        grant_valid;
    logic [IDX_W-1:0]            grant_idx;
    logic [LANE_W-1:0]           grant_data;
    logic                        grant_ready;
    logic [NUM_LANES-1:0]        lane_clr;
    logic                        busy;

    modport slave (
        input  req_vec, cfg_left, cfg_right, cfg_load, grant_ready,
        output cfg_err, grant_valid, grant_idx, grant_data, lane_clr, busy
    );

    modport master (
        output req_vec, cfg_left, cfg_right, cfg_load, grant_ready,
        input  cfg_err, grant_valid, grant_idx, grant_data, lane_clr, busy
    );
endinterface

// File: rtl/encoder_scheduler.sv
// Round-robin scheduler sharing one lane priority-encode search across the
// encoder requesters. It scans the window [win_left..win_right] (inclusive,
// wrap-around) from a rotating pointer, presents the first non-zero lane on a
// valid/ready grant, then pulses a one-hot lane_clr back to that requester.
// Ports: clk, rst_n (async, active-low); bus (slave modport): req_vec,
// cfg_left/cfg_right/cfg_load/cfg_err, grant_valid/grant_idx/grant_data/
// grant_ready, lane_clr, busy. All bus outputs are registered.
module encoder_scheduler #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned LANE_W    = 8,
    parameter int unsigned IDX_W     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    encoder_scheduler_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SCAN, GRANT, CLR} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     win_left_q, win_left_d;
    logic [IDX_W-1:0]     win_right_q, win_right_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
    logic [LANE_W-1:0]    grant_data_q, grant_data_d;
    logic                 grant_valid_q, grant_valid_d;
    logic [NUM_LANES-1:0] lane_clr_q, lane_clr_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 busy_q, busy_d;

    logic [NUM_LANES-1:0] lane_nz;
    logic                 found;
    logic [IDX_W-1:0]     win_idx;
    logic                 cfg_ok;

    // Window membership, handling the wrapped case (left > right).
    function automatic logic in_win(input logic [IDX_W-1:0] i,
                                    input logic [IDX_W-1:0] l,
                                    input logic [IDX_W-1:0] r);
        if (l <= r) return (i >= l) && (i <= r);
        return (i >= l) || (i <= r);
    endfunction

    // (base + k) mod NUM_LANES; k never exceeds NUM_LANES so one subtract suffices.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned    k);
        int unsigned c;
        c = 32'(base) + k;
        if (c >= NUM_LANES) c = c - NUM_LANES;
        return IDX_W'(c);
    endfunction

    // Window member following idx in search order; a one-lane window returns idx.
    function automatic logic [IDX_W-1:0] next_after(input logic [IDX_W-1:0] idx,
                                                    input logic [IDX_W-1:0] l,
                                                    input logic [IDX_W-1:0] r);
        logic [IDX_W-1:0] res;
        logic [IDX_W-1:0] c;
        logic             hit;
        res = idx;
        hit = 1'b0;
        for (int unsigned k = 1; k < NUM_LANES; k++) begin
            c = wrap_add(idx, k);
            if (!hit && in_win(c, l, r)) begin
                res = c;
                hit = 1'b1;
            end
        end
        return res;
    endfunction

    // Per-lane request flags.
    always_comb begin : lane_flags
        lane_nz = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            lane_nz[i] = |bus.req_vec[i*LANE_W +: LANE_W];
        end
    end

    // First requesting window lane at or after ptr; ptr is always a window member,
    // so a plain modular walk that skips non-members follows the search order.
    always_comb begin : search
        logic [IDX_W-1:0] cand;
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            cand = wrap_add(ptr_q, k);
            if (!found && in_win(cand, win_left_q, win_right_q) && lane_nz[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign cfg_ok = ({1'b0, bus.cfg_left}  < (IDX_W+1)'(NUM_LANES)) &&
                    ({1'b0, bus.cfg_right} < (IDX_W+1)'(NUM_LANES));

    // Next-state and next-output logic.
    always_comb begin : next_state
        state_d      = state_q;
        win_left_d   = win_left_q;
        win_right_d  = win_right_q;
        ptr_d        = ptr_q;
        grant_idx_d  = grant_idx_q;
        grant_data_d = grant_data_q;
        cfg_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cfg_load) begin
                    if (cfg_ok) begin
                        win_left_d  = bus.cfg_left;
                        win_right_d = bus.cfg_right;
                        ptr_d       = bus.cfg_left;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end else if (found) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // Requests may have vanished since IDLE; drop back without a grant.
                if (found) begin
                    grant_idx_d  = win_idx;
                    grant_data_d = bus.req_vec[32'(win_idx)*LANE_W +: LANE_W];
                    state_d      = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (grant_valid_q && bus.grant_ready) begin
                    ptr_d   = next_after(grant_idx_q, win_left_q, win_right_q);
                    state_d = CLR;
                end
            end
            CLR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        grant_valid_d = (state_d == GRANT);
        lane_clr_d    = (state_d == CLR) ? (NUM_LANES'(1) << grant_idx_d) : '0;
        busy_d        = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            win_left_q    <= '0;
            win_right_q   <= IDX_W'(NUM_LANES - 1);
            ptr_q         <= '0;
            grant_idx_q   <= '0;
            grant_data_q  <= '0;
            grant_valid_q <= 1'b0;
            lane_clr_q    <= '0;
            cfg_err_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            win_left_q    <= win_left_d;
            win_right_q   <= win_right_d;
            ptr_q         <= ptr_d;
            grant_idx_q   <= grant_idx_d;
            grant_data_q  <= grant_data_d;
            grant_valid_q <= grant_valid_d;
            lane_clr_q    <= lane_clr_d;
            cfg_err_q     <= cfg_err_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_idx   = grant_idx_q;
    assign bus.grant_data  = grant_data_q;
    assign bus.lane_clr    = lane_clr_q;
    assign bus.cfg_err     = cfg_err_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_encoder_scheduler.sv
// Directed bench for encoder_scheduler: a 4-lane instance for the main
// scenarios and a 6-lane instance for out-of-range configuration.
module tb_encoder_scheduler;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    encoder_scheduler_if #(.NUM_LANES(4), .LANE_W(8), .IDX_W(2)) bus  ();
    encoder_scheduler_if #(.NUM_LANES(6), .LANE_W(8), .IDX_W(3)) bus6 ();

    encoder_scheduler #(.NUM_LANES(4), .LANE_W(8), .IDX_W(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    encoder_scheduler #(.NUM_LANES(6), .LANE_W(8), .IDX_W(3)) u_dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus6)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Poll for grant_valid on one of the two instances, bounded by budget cycles.
    task automatic wait_grant(input bit six, input int budget, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < budget) begin
            if ((six ? bus6.grant_valid : bus.grant_valid) === 1'b1) ok = 1'b1;
            else begin
                tick();
                n++;
            end
        end
    endtask

    task automatic load_cfg(input logic [1:0] l, input logic [1:0] r);
        bus.cfg_left  = l;
        bus.cfg_right = r;
        bus.cfg_load  = 1'b1;
        tick();
        bus.cfg_load  = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({bus.grant_valid, bus.busy, bus.cfg_err, bus.lane_clr} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 0", {bus.grant_valid, bus.busy, bus.cfg_err, bus.lane_clr});
        end
        checks++;
        if ({bus.grant_idx, bus.grant_data} !== 10'h0) begin
            errors++;
            $display("FAIL reset_grant got idx=%0d data=%h want 0/00", bus.grant_idx, bus.grant_data);
        end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy got %b want 0", bus.busy);
        end
    endtask

    task automatic test_basic();
        bit ok;
        bus.grant_ready = 1'b1;
        bus.req_vec     = 32'h0300_0100;
        wait_grant(1'b0, 10, ok);
        checks++;
        if (!ok || bus.grant_idx !== 2'd1 || bus.grant_data !== 8'h01) begin
            errors++;
            $display("FAIL basic_grant1 got ok=%0b idx=%0d data=%h want idx=1 data=01", ok, bus.grant_idx, bus.grant_data);
        end
        tick();
        checks++;
        if (bus.lane_clr !== 4'b0010) begin
            errors++;
            $display("FAIL basic_clr1 got %b want 0010", bus.lane_clr);
        end
        bus.req_vec = 32'h0300_0000;
        wait_grant(1'b0, 10, ok);
        checks++;
        if (!ok || bus.grant_idx !== 2'd3 || bus.grant_data !== 8'h03) begin
            errors++;
            $display("FAIL basic_grant2 got ok=%0b idx=%0d data=%h want idx=3 data=03", ok, bus.grant_idx, bus.grant_data);
        end
        tick();
        checks++;
        if (bus.lane_clr !== 4'b1000) begin
            errors++;
            $display("FAIL basic_clr2 got %b want 1000", bus.lane_clr);
        end
        bus.req_vec = '0;
        tick();
        tick();
    endtask

    task automatic test_window();
        bit ok;
        bit stray;
        load_cfg(2'd1, 2'd2);
        checks++;
        if (bus.cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL window_cfg_err got %b want 0", bus.cfg_err);
        end
        bus.req_vec = 32'h0705_00AA;
        wait_grant(1'b0, 10, ok);
        checks++;
        if (!ok || bus.grant_idx !== 2'd2 || bus.grant_data !== 8'h05) begin
            errors++;
            $display("FAIL window_grant got ok=%0b idx=%0d data=%h want idx=2 data=05", ok, bus.grant_idx, bus.grant_data);
        end
        tick();
        checks++;
        if (bus.lane_clr !== 4'b0100) begin
            errors++;
            $display("FAIL window_clr got %b want 0100", bus.lane_clr);
        end
        bus.req_vec = 32'h0700_00AA;
        tick();
        stray = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.busy !== 1'b0 || bus.grant_valid !== 1'b0) stray = 1'b1;
            tick();
        end
        checks++;
        if (stray !== 1'b0) begin
            errors++;
            $display("FAIL window_outside_lanes got activity=%b want 0", stray);
        end
        bus.req_vec = '0;
        tick();
    endtask

    task automatic test_wrapped();
        bit ok;
        bit stray;
        load_cfg(2'd3, 2'd0);
        bus.req_vec = 32'h0044_0000;
        stray = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.busy !== 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray !== 1'b0) begin
            errors++;
            $display("FAIL wrap_lane2_busy got busy_seen=%b want 0", stray);
        end
        bus.req_vec = 32'h2200_0011;
        wait_grant(1'b0, 10, ok);
        checks++;
        if (!ok || bus.grant_idx !== 2'd3 || bus.grant_data !== 8'h22) begin
            errors++;
            $display("FAIL wrap_grant1 got ok=%0b idx=%0d data=%h want idx=3 data=22", ok, bus.grant_idx, bus.grant_data);
        end
        tick();
        bus.req_vec = 32'h0000_0011;
        wait_grant(1'b0, 10, ok);
        checks++;
        if (!ok || bus.grant_idx !== 2'd0 || bus.grant_data !== 8'h11) begin
            errors++;
            $display("FAIL wrap_grant2 got ok=%0b idx=%0d data=%h want idx=0 data=11", ok, bus.grant_idx, bus.grant_data);
        end
        tick();
        bus.req_vec = '0;
        tick();
        tick();
    endtask

    task automatic test_all_ff();
        bit          ok;
        int          prev;
        logic [1:0]  exp_seq [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        load_cfg(2'd0, 2'd3);
        bus.req_vec = 32'hFFFF_FFFF;
        prev = 0;
        for (int g = 0; g < 6; g++) begin
            wait_grant(1'b0, 10, ok);
            checks++;
            if (!ok || bus.grant_idx !== exp_seq[g]) begin
                errors++;
                $display("FAIL allff_seq%0d got ok=%0b idx=%0d want %0d", g, ok, bus.grant_idx, exp_seq[g]);
            end
            if (g > 0) begin
                checks++;
                if (cyc - prev !== 4) begin
                    errors++;
                    $display("FAIL allff_spacing%0d got %0d want 4", g, cyc - prev);
                end
            end
            prev = cyc;
            tick();
        end
        bus.req_vec = '0;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        bit          ok;
        bit          held;
        int          pulses;
        logic [3:0]  clr_seen;
        logic [31:0] toggles [6] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h1234_5678,
                                     32'h0000_5A00, 32'h8000_0001, 32'h0F0F_0F0F};
        bus.grant_ready = 1'b0;
        bus.req_vec     = 32'h0000_5A00;
        wait_grant(1'b0, 10, ok);
        checks++;
        if (!ok || bus.grant_idx !== 2'd1 || bus.grant_data !== 8'h5A) begin
            errors++;
            $display("FAIL bp_grant got ok=%0b idx=%0d data=%h want idx=1 data=5A", ok, bus.grant_idx, bus.grant_data);
        end
        bus.cfg_left  = 2'd2;
        bus.cfg_right = 2'd3;
        bus.cfg_load  = 1'b1;
        held = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.req_vec = toggles[i];
            tick();
            if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 2'd1 ||
                bus.grant_data !== 8'h5A || bus.cfg_err !== 1'b0) held = 1'b0;
        end
        checks++;
        if (held !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold got valid=%b idx=%0d data=%h err=%b want 1/1/5A/0",
                     bus.grant_valid, bus.grant_idx, bus.grant_data, bus.cfg_err);
        end
        bus.cfg_load    = 1'b0;
        bus.req_vec     = '0;
        bus.grant_ready = 1'b1;
        pulses   = 0;
        clr_seen = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.lane_clr !== 4'b0000) begin
                pulses++;
                clr_seen = bus.lane_clr;
            end
        end
        checks++;
        if (pulses !== 1 || clr_seen !== 4'b0010) begin
            errors++;
            $display("FAIL bp_clr got pulses=%0d value=%b want 1/0010", pulses, clr_seen);
        end
        // Lane 0 is only reachable if the full default window survived the ignored load.
        bus.req_vec = 32'h0000_00C3;
        wait_grant(1'b0, 10, ok);
        checks++;
        if (!ok || bus.grant_idx !== 2'd0 || bus.grant_data !== 8'hC3) begin
            errors++;
            $display("FAIL bp_window_kept got ok=%0b idx=%0d data=%h want idx=0 data=C3", ok, bus.grant_idx, bus.grant_data);
        end
        tick();
        bus.req_vec = '0;
        tick();
        tick();
    endtask

    task automatic test_illegal_cfg();
        bit ok;
        bus6.cfg_left  = 3'd7;
        bus6.cfg_right = 3'd2;
        bus6.cfg_load  = 1'b1;
        tick();
        bus6.cfg_load  = 1'b0;
        checks++;
        if (bus6.cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_err_pulse got %b want 1", bus6.cfg_err);
        end
        tick();
        checks++;
        if (bus6.cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL illegal_err_single got %b want 0", bus6.cfg_err);
        end
        bus6.grant_ready = 1'b1;
        bus6.req_vec     = 48'h5E00_0000_0000;
        wait_grant(1'b1, 10, ok);
        checks++;
        if (!ok || bus6.grant_idx !== 3'd5 || bus6.grant_data !== 8'h5E) begin
            errors++;
            $display("FAIL illegal_window_kept got ok=%0b idx=%0d data=%h want idx=5 data=5E", ok, bus6.grant_idx, bus6.grant_data);
        end
        tick();
        bus6.req_vec = '0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_grant();
        bit ok;
        bus.grant_ready = 1'b0;
        bus.req_vec     = 32'h4433_2211;
        wait_grant(1'b0, 10, ok);
        checks++;
        if (!ok || bus.grant_idx !== 2'd1) begin
            errors++;
            $display("FAIL rst_pre_grant got ok=%0b idx=%0d want idx=1", ok, bus.grant_idx);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.grant_valid, bus.busy, bus.cfg_err, bus.lane_clr, bus.grant_idx, bus.grant_data} !== 17'h0) begin
            errors++;
            $display("FAIL rst_async got valid=%b busy=%b err=%b clr=%b idx=%0d data=%h want all 0",
                     bus.grant_valid, bus.busy, bus.cfg_err, bus.lane_clr, bus.grant_idx, bus.grant_data);
        end
        tick();
        rst_n = 1'b1;
        bus.grant_ready = 1'b1;
        wait_grant(1'b0, 10, ok);
        checks++;
        if (!ok || bus.grant_idx !== 2'd0 || bus.grant_data !== 8'h11) begin
            errors++;
            $display("FAIL rst_first_grant got ok=%0b idx=%0d data=%h want idx=0 data=11", ok, bus.grant_idx, bus.grant_data);
        end
        tick();
        bus.req_vec = '0;
        tick();
    endtask

    initial begin
        bus.req_vec      = '0;
        bus.cfg_left     = '0;
        bus.cfg_right    = '0;
        bus.cfg_load     = 1'b0;
        bus.grant_ready  = 1'b0;
        bus6.req_vec     = '0;
        bus6.cfg_left    = '0;
        bus6.cfg_right   = '0;
        bus6.cfg_load    = 1'b0;
        bus6.grant_ready = 1'b0;

        test_reset();
        test_basic();
        test_window();
        test_wrapped();
        test_all_ff();
        test_back_to_back();
        test_illegal_cfg();
        test_reset_mid_grant();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
